// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. It holds the program counter, drives it straight
// to a zero-latency instruction ROM, and captures the returned word into the
// IF/ID pipeline register. Hazard stalls (freeze) hold the stage. Redirects
// (branch_taken) load a new PC and flush the IF/ID register to a NOP.
//
// Optional feature: define FETCH_PERF_CNT_EN to add saturating fetch/flush
// performance counters and their output ports.
//
// Parameters
//   RESET_PC      PC loaded on reset (must be word-aligned)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   freeze        hazard stall: holds PC and IF/ID register
//   branch_taken  redirect request (wins over freeze)
//   branch_addr   redirect byte address (bits [1:0] ignored)
//   rom_addr      byte address to instruction ROM (equals PC)
//   rom_inst      instruction word returned by ROM for rom_addr
//   if_pc         registered PC+4 of the captured instruction
//   if_inst       registered instruction for decode
//   if_valid      registered: if_inst is a real fetched instruction
//   fetch_count   (FETCH_PERF_CNT_EN only) saturating count of captures
//   flush_count   (FETCH_PERF_CNT_EN only) saturating count of flushes
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    // What the stage does on the coming edge (reset handled separately).
    typedef enum logic [1:0] {
        ACT_FETCH,
        ACT_HOLD,
        ACT_FLUSH
    } act_e;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] branch_pc;
    act_e        act;

    // Low address bits of the redirect target are deliberately dropped.
    logic        unused_branch_lsbs;
    assign unused_branch_lsbs = ^branch_addr[1:0];

    assign branch_pc = {branch_addr[31:2], 2'b00};
    // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
    assign pc_plus4  = pc + 32'd4;

    // Zero-latency ROM: the address is the PC register itself, so every
    // output of this block comes from a flop.
    assign rom_addr  = pc;

    // Redirect has priority over stall.
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        act = ACT_FETCH;
        if (branch_taken) begin
            act = ACT_FLUSH;
        end else if (freeze) begin
            act = ACT_HOLD;
        end
    end

    // PC and IF/ID register. Reset overrides both redirect and stall.
    // NOTE: sequential state uses non-blocking (<=) assignments so all flops
    // sample their inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            if_inst  <= 32'h0;
            if_pc    <= 32'h0;
            if_valid <= 1'b0;
        end else begin
            unique case (act)
                ACT_FLUSH: begin
                    pc       <= branch_pc;
                    if_inst  <= 32'h0;
                    if_pc    <= 32'h0;
                    if_valid <= 1'b0;
                end
                ACT_FETCH: begin
                    pc       <= pc_plus4;
                    if_inst  <= rom_inst;
                    if_pc    <= pc_plus4;
                    if_valid <= 1'b1;
                end
                default: begin
                    // ACT_HOLD: every register keeps its value.
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters; they stop at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 32'h0;
            flush_count <= 32'h0;
        end else begin
            if (act == ACT_FETCH && fetch_count != 32'hFFFF_FFFF) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (act == ACT_FLUSH && flush_count != 32'hFFFF_FFFF) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Scoreboard bench for fetch_stage. A driver applies directed then random
// stimulus on the falling edge and pushes the expected post-edge state from a
// behavioural model into a queue; a monitor pops and compares just after each
// rising edge. A second instance with RESET_PC = FFFF_FFFC checks PC wrap
// out of reset. Perf counters are checked when FETCH_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
    logic [31:0] w_fetch_count;
    logic [31:0] w_flush_count;
`endif

    // Second instance: reset PC at the top of the address space.
    logic [31:0] w_rom_addr;
    logic [31:0] w_rom_inst;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_inst;
    logic        w_if_valid;

    logic [31:0] rom_mem [1024];

    always #5 clk = ~clk;

    assign rom_inst   = rom_mem[rom_addr[11:2]];
    assign w_rom_inst = rom_mem[w_rom_addr[11:2]];

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .rom_addr     (rom_addr),
        .rom_inst     (rom_inst),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_valid     (if_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count),
        .flush_count  (flush_count)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .freeze       (1'b0),
        .branch_taken (1'b0),
        .branch_addr  (32'h0),
        .rom_addr     (w_rom_addr),
        .rom_inst     (w_rom_inst),
        .if_pc        (w_if_pc),
        .if_inst      (w_if_inst),
        .if_valid     (w_if_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (w_fetch_count),
        .flush_count  (w_flush_count)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic [31:0] fcnt;
        logic [31:0] flcnt;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model state: the architectural meaning of the stage.
    logic [31:0] m_pc, m_ifpc, m_inst;
    logic        m_valid;
    longint      m_fetches, m_flushes;

    // One cycle: drive inputs on the falling edge, advance the model by the
    // rules of the next rising edge, and queue what the DUT should then show.
    task automatic step(input logic r, input logic f, input logic b, input logic [31:0] a);
        exp_t e;
        @(negedge clk);
        rst          = r;
        freeze       = f;
        branch_taken = b;
        branch_addr  = a;
        if (r) begin
            m_pc = 32'h0; m_ifpc = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
            m_fetches = 0; m_flushes = 0;
        end else if (b) begin
            m_pc = a & ~32'd3; m_ifpc = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
            m_flushes++;
        end else if (!f) begin
            m_inst  = rom_mem[(m_pc % 4096) / 4];
            m_pc    = 32'((longint'(m_pc) + 4) % 64'h1_0000_0000);
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            m_fetches++;
        end
        e.addr  = m_pc;
        e.pc    = m_ifpc;
        e.inst  = m_inst;
        e.valid = m_valid;
        e.fcnt  = (m_fetches > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_fetches);
        e.flcnt = (m_flushes > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_flushes);
        q.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("rom_addr", rom_addr, e.addr);
                check("if_pc", if_pc, e.pc);
                check("if_inst", if_inst, e.inst);
                check("if_valid", {31'h0, if_valid}, {31'h0, e.valid});
`ifdef FETCH_PERF_CNT_EN
                check("fetch_count", fetch_count, e.fcnt);
                check("flush_count", flush_count, e.flcnt);
`endif
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic        r, f, b;
        for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
        rom_mem[0] = 32'h8001_060A;
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        m_pc = 32'h0; m_ifpc = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
        m_fetches = 0; m_flushes = 0;

        // Two reset cycles with redirect/stall asserted: reset must win.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        step(1'b1, 1'b0, 1'b0, 32'h0);

        // First free-run capture: word 0 at PC 0, if_pc 4.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        check("wrap_rom_addr", w_rom_addr, 32'h0);
        check("wrap_if_pc", w_if_pc, 32'h0);
        check("wrap_if_valid", {31'h0, w_if_valid}, 32'h1);
        check("wrap_if_inst", w_if_inst, rom_mem[1023]);

        step(1'b0, 1'b0, 1'b0, 32'h0);           // PC -> 8
        step(1'b0, 1'b1, 1'b0, 32'h0);           // freeze at 8
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);           // PC -> 12
        step(1'b0, 1'b0, 1'b0, 32'h0);           // PC -> 16
        step(1'b0, 1'b1, 1'b1, 32'h0000_0033);   // redirect beats freeze -> 0x30
        step(1'b0, 1'b0, 1'b0, 32'h0);           // word at 0x30, if_pc 0x34

        // Redirect to the top of memory and run across the wrap.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF7);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset in the middle of a stall, then release.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 39) == 0);
            f = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
            else a = $urandom;
            step(r, f, b, a);
        end

        step(1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #3;
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
